flag_buf_fifo: RTL and testbench

Parametrised successor to the single-entry UART transmit flag buffer: a small first-word-fall-through queue between the command/datapath side and the UART transmitter. It holds up to `DEPTH` words of `DATA_W` bits, so the producer can post several characters back-to-back. It exposes a non-empty `flag` and the head word to the transmitter, and reports full and overrun conditions.

---
 rtl/flag_buf_fifo.sv | 80 ++++++++
 tb/tb_flag_buf_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/flag_buf_fifo.sv
// flag_buf_fifo: first-word-fall-through queue feeding the UART transmitter.
// Define FLAG_BUF_OVERWRITE_EN to make a push into a full queue evict the oldest word.
module flag_buf_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_flag,
  input  logic [DATA_W-1:0]        din,
  input  logic                     clr_flag,
  output logic                     flag,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              is_empty;
  logic              is_full;
  logic              do_push;
  logic              do_pop;
  logic              ovr_evt;
  logic              wr_en;
  logic              rd_adv;

  // Strobe semantics: set_flag pushes din on any edge where it is high and there
  // is room (or a pop frees a slot that same edge); clr_flag pops the head on any
  // edge where the queue is non-empty. The producer never waits; refused pushes
  // are reported through overrun instead of back-pressure.
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign do_pop   = clr_flag & ~is_empty;
  assign do_push  = set_flag & (~is_full | do_pop);
  assign ovr_evt  = set_flag & is_full & ~clr_flag;

`ifdef FLAG_BUF_OVERWRITE_EN
  // Overwrite: evict the head and write the new word in one edge, count unchanged.
  assign wr_en  = do_push | ovr_evt;
  assign rd_adv = do_pop  | ovr_evt;
`else
  assign wr_en  = do_push;
  assign rd_adv = do_pop;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_adv)      cnt <= cnt + CNT_ONE;
      else if (rd_adv && !wr_en) cnt <= cnt - CNT_ONE;
      overrun <= ovr_evt;
    end
  end

  // Storage is never reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  assign flag  = ~is_empty;
  assign full  = is_full;
  assign count = cnt;
  assign dout  = is_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_flag_buf_fifo.sv
// Directed self-checking bench for flag_buf_fifo (DATA_W=8, DEPTH=4).
// Expected overrun drain order follows FLAG_BUF_OVERWRITE_EN when defined.
module tb_flag_buf_fifo;

  logic       clk;
  logic       reset;
  logic       set_flag;
  logic [7:0] din;
  logic       clr_flag;
  logic       flag;
  logic [7:0] dout;
  logic       full;
  logic [2:0] count;
  logic       overrun;

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  flag_buf_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .set_flag(set_flag), .din(din),
    .clr_flag(clr_flag), .flag(flag), .dout(dout), .full(full),
    .count(count), .overrun(overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of strobes at negedge, return 1 time unit after posedge
  task automatic cycle(input logic s, input logic [7:0] d, input logic c);
    @(negedge clk);
    set_flag = s;
    din      = d;
    clr_flag = c;
    @(posedge clk);
    #1;
    set_flag = 1'b0;
    clr_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; set_flag = 1'b0; clr_flag = 1'b0; din = 8'h00;
    #12;
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", flag); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_fill();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL midfill_count got=%0d exp=2", count); end
    checks++; if (dout !== 8'h11) begin failures++; $display("FAIL midfill_dout got=%h exp=11", dout); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL async_flag got=%b exp=0", flag); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", count); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL async_dout got=%h exp=00", dout); end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 8'h33, 1'b0);
    checks++; if (dout !== 8'h33) begin failures++; $display("FAIL after_reset_dout got=%h exp=33", dout); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL after_reset_count got=%0d exp=1", count); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL after_reset_pop_flag got=%b exp=0", flag); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      exp = 8'hA1 + 8'(i);
      cycle(1'b1, exp, 1'b0);
      exp_q.push_back(exp);
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++; if (dout !== exp) begin failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, exp); end
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL drain_flag got=%b exp=0", flag); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL drain_dout_empty got=%h exp=00", dout); end
    cycle(1'b0, 8'h00, 1'b1);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL pop_empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      exp = 8'h30 + 8'(i * 7);
      cycle(1'b1, exp, 1'b0);
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
      checks++; if (dout !== exp) begin failures++; $display("FAIL wrap_dout[%0d] got=%h exp=%h", i, dout, exp); end
      cycle(1'b0, 8'h00, 1'b1);
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_pop_count[%0d] got=%0d exp=0", i, count); end
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 8'h5A, 1'b1);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
    checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL simul_empty_dout got=%h exp=5a", dout); end
    cycle(1'b1, 8'h6B, 1'b1);
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL simul_partial_count got=%0d exp=1", count); end
    checks++; if (dout !== 8'h6B) begin failures++; $display("FAIL simul_partial_dout got=%h exp=6b", dout); end
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp = 8'hA1 + 8'(i);
      cycle(1'b1, exp, 1'b0);
      exp_q.push_back(exp);
    end
    cycle(1'b1, 8'hB5, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'hB5);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL simul_full_count got=%0d exp=4", count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL simul_full_overrun got=%b exp=0", overrun); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++; if (dout !== exp) begin failures++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, dout, exp); end
      cycle(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) begin
      exp = 8'hA1 + 8'(i);
      cycle(1'b1, exp, 1'b0);
      exp_q.push_back(exp);
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun); end
    cycle(1'b1, 8'hFF, 1'b0);
`ifdef FLAG_BUF_OVERWRITE_EN
    void'(exp_q.pop_front());
    exp_q.push_back(8'hFF);
`endif
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", count); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++; if (dout !== exp) begin failures++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, dout, exp); end
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++; if (flag !== 1'b0) begin failures++; $display("FAIL ovr_empty_flag got=%b exp=0", flag); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_reset_mid_fill();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
